// File: rtl/vecseq_pkg.sv
// Shared definitions for vector_sequencer: FSM encoding, packed-vector field layout
// and the Galois LFSR tap mask and step function.
package vecseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIRECTED = 2'd1,
        ST_RANDOM   = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    // Packed vector is {data, a, b, x[4:0]}, MSB first.
    localparam int X_LSB     = 0;
    localparam int X_W       = 5;
    localparam int B_POS     = 5;
    localparam int A_POS     = 6;
    localparam int DATA_LSB  = 7;
    localparam int VEC_EXTRA = 7;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/vecseq_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load and step enable.
// Exposes the low OUT_W bits of the current and the following state.
module vecseq_lfsr
    import vecseq_pkg::*;
#(
    parameter logic [31:0] SEED  = 32'hACE1_2468,
    parameter int          OUT_W = 15
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [OUT_W-1:0] state,
    output logic [OUT_W-1:0] state_next
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic [31:0] lfsr_step_val;

    assign lfsr_step_val = lfsr_next(lfsr_q);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = SEED;
        end else if (step) begin
            lfsr_d = lfsr_step_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state      = lfsr_q[OUT_W-1:0];
    assign state_next = lfsr_step_val[OUT_W-1:0];

endmodule

// File: rtl/vector_sequencer.sv
// Replays preloaded directed vectors, then (with RANDOM_PHASE_EN defined) LFSR vectors,
// over a valid/ready handshake. Without RANDOM_PHASE_EN the run ends after the directed phase.
module vector_sequencer
    import vecseq_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          DEPTH       = 10,
    parameter int          RAND_CYCLES = 30,
    parameter logic [31:0] SEED        = 32'hACE1_2468,
    localparam int         AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         VW          = WIDTH + VEC_EXTRA
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [VW-1:0]    load_data,
    input  logic             start,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             a,
    output logic             b,
    output logic [4:0]       x,
    output logic             busy,
    output logic             done,
    output logic [15:0]      vec_cnt
);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d, idx_nxt;
    logic [VW-1:0] vec_q, vec_d, vec0;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   cnt_q, cnt_d, cnt_inc;
    logic          accept;
    logic          addr_ok;
    logic          mem_we;
    logic [VW-1:0] mem_q [DEPTH];

    assign accept  = valid_q & out_ready;
    assign addr_ok = (32'(load_addr) < 32'(DEPTH));
    assign mem_we  = load_en & addr_ok & (state_q == ST_IDLE);
    assign idx_nxt = idx_q + AW'(1);
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // A write to entry 0 in the start cycle must be seen by the first vector.
    assign vec0 = (mem_we && load_addr == '0) ? load_data : mem_q[0];

    // NOTE: the vector memory has no reset so it maps onto RAM and survives rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[load_addr] <= load_data;
        end
    end

`ifdef RANDOM_PHASE_EN
    localparam int RW = $clog2(RAND_CYCLES + 1);

    logic [RW-1:0] rnd_q, rnd_d;
    logic          lfsr_load;
    logic          lfsr_step;
    logic [VW-1:0] lfsr_vec;
    logic [VW-1:0] lfsr_vec_next;

    vecseq_lfsr #(
        .SEED  (SEED),
        .OUT_W (VW)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .step       (lfsr_step),
        .state      (lfsr_vec),
        .state_next (lfsr_vec_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_q <= '0;
        end else begin
            rnd_q <= rnd_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{SEED, 32'(RAND_CYCLES)};
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
`ifdef RANDOM_PHASE_EN
        rnd_d     = rnd_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_DIRECTED;
                    idx_d   = '0;
                    vec_d   = vec0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
`ifdef RANDOM_PHASE_EN
                    rnd_d     = '0;
                    lfsr_load = 1'b1;
`endif
                end
            end
            ST_DIRECTED: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (idx_q == AW'(DEPTH - 1)) begin
`ifdef RANDOM_PHASE_EN
                        state_d = ST_RANDOM;
                        vec_d   = lfsr_vec;
`else
                        state_d = ST_DONE;
                        valid_d = 1'b0;
`endif
                    end else begin
                        idx_d = idx_nxt;
                        vec_d = mem_q[idx_nxt];
                    end
                end
            end
`ifdef RANDOM_PHASE_EN
            ST_RANDOM: begin
                if (accept) begin
                    cnt_d     = cnt_inc;
                    lfsr_step = 1'b1;
                    if (rnd_q == RW'(RAND_CYCLES - 1)) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                    end else begin
                        rnd_d = rnd_q + RW'(1);
                        vec_d = lfsr_vec_next;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ST_DIRECTED) || (state_d == ST_RANDOM);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vec_q   <= vec_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = vec_q[DATA_LSB +: WIDTH];
    assign a         = vec_q[A_POS];
    assign b         = vec_q[B_POS];
    assign x         = vec_q[X_LSB +: X_W];
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: randomized ready, stalls, mid-run reset and
// ignored loads, checked against an expected-vector queue built from memory contents and the LFSR polynomial.
module tb_vector_sequencer;

    localparam int          WIDTH       = 8;
    localparam int          DEPTH       = 10;
    localparam int          RAND_CYCLES = 30;
    localparam logic [31:0] SEED        = 32'hACE1_2468;
    localparam int          AW          = $clog2(DEPTH);
    localparam int          VW          = WIDTH + 7;
`ifdef RANDOM_PHASE_EN
    localparam int          TOTAL       = DEPTH + RAND_CYCLES;
`else
    localparam int          TOTAL       = DEPTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_en;
    logic [AW-1:0]    load_addr;
    logic [VW-1:0]    load_data;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             a;
    logic             b;
    logic [4:0]       x;
    logic             busy;
    logic             done;
    logic [15:0]      vec_cnt;

    vector_sequencer #(
        .WIDTH       (WIDTH),
        .DEPTH       (DEPTH),
        .RAND_CYCLES (RAND_CYCLES),
        .SEED        (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .data_out  (data_out),
        .a         (a),
        .b         (b),
        .x         (x),
        .busy      (busy),
        .done      (done),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [VW-1:0] mem_model [DEPTH];
    logic [VW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {data_out, a, b, x};
    endfunction

    // One step of the Galois LFSR, taps taken straight from the polynomial exponents.
    function automatic logic [31:0] galois_step(input logic [31:0] s);
        logic [31:0] taps;
        int          exps [4];
        exps = '{32, 22, 2, 1};
        taps = '0;
        foreach (exps[i]) taps[exps[i]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    function automatic void build_expected();
        logic [31:0] r;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(mem_model[i]);
        r = SEED;
`ifdef RANDOM_PHASE_EN
        for (int k = 0; k < RAND_CYCLES; k++) begin
            exp_q.push_back(r[VW-1:0]);
            r = galois_step(r);
        end
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_cnt"},   32'(vec_cnt),   32'd0);
        check({tag, "_vec"},   32'(obs_vec()), 32'd0);
    endtask

    task automatic load_vec(input int addr, input logic [VW-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
        if (addr < DEPTH) mem_model[addr] = data;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives one run from the first presented vector. stall_idx: hold ready low 3 clks there.
    // poke_idx: pulse start plus a load to addr 2 there (both must be ignored). stop_idx: return early.
    task automatic run_vectors(input int ready_pct, input int stall_idx,
                               input int poke_idx, input int stop_idx);
        int pos        = 0;
        int cycles     = 0;
        int stall_left = 3;
        bit poked      = 1'b0;
        build_expected();
        while (pos < TOTAL && cycles < 4000) begin
            start   = 1'b0;
            load_en = 1'b0;
            check("run_valid", 32'(out_valid), 32'd1);
            check("run_busy",  32'(busy),      32'd1);
            check("run_done",  32'(done),      32'd0);
            check("run_vec",   32'(obs_vec()), 32'(exp_q[pos]));
            check("run_cnt",   32'(vec_cnt),   32'(pos));
            if (pos == stop_idx) begin
                out_ready = 1'b0;
                return;
            end
            if (pos == poke_idx && !poked) begin
                poked     = 1'b1;
                start     = 1'b1;
                load_en   = 1'b1;
                load_addr = AW'(2);
                load_data = ~mem_model[2];
            end
            if (pos == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            tick();
            if (out_ready) pos++;
            cycles++;
        end
        start     = 1'b0;
        load_en   = 1'b0;
        out_ready = 1'b0;
        check("run_complete", 32'(pos), 32'(TOTAL));
        for (int h = 0; h < 2; h++) begin
            check("end_done",  32'(done),      32'd1);
            check("end_valid", 32'(out_valid), 32'd0);
            check("end_busy",  32'(busy),      32'd0);
            check("end_cnt",   32'(vec_cnt),   32'(TOTAL));
            check("end_hold",  32'(obs_vec()), 32'(exp_q[TOTAL-1]));
            out_ready = 1'(h);
            tick();
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        out_ready = 1'b0;

        #3;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("idle");

        // Directed contents: x = i, data = 0xA0 + i, a = b = 0.
        for (int i = 0; i < DEPTH; i++) begin
            load_vec(i, {8'(8'hA0 + i), 1'b0, 1'b0, 5'(i)});
        end
        load_vec(12, '1);
        load_vec(15, '1);

        // Full-rate run.
        do_start();
        run_vectors(100, -1, -1, -1);

        // Stall for 3 clks while vec 4 is presented.
        do_start();
        run_vectors(100, 4, -1, -1);

        // Asynchronous reset while vec 6 is presented.
        do_start();
        run_vectors(100, -1, -1, 6);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("post_rst");

        // Replay after reset with the same memory, random backpressure.
        do_start();
        run_vectors(70, -1, -1, -1);

        // Load and start during a run are ignored; the restart shows the original contents.
        do_start();
        run_vectors(100, -1, 3, -1);
        do_start();
        run_vectors(80, -1, -1, -1);

        // Fresh random contents; the write to entry 0 shares its cycle with start.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 1; i < DEPTH; i++) begin
            load_vec(i, VW'($urandom));
        end
        load_en   = 1'b1;
        load_addr = '0;
        load_data = VW'($urandom);
        mem_model[0] = load_data;
        start     = 1'b1;
        tick();
        load_en   = 1'b0;
        start     = 1'b0;
        run_vectors(50, -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
